// File: rtl/mem_stage_sram_ctrl_if.sv
// mem_stage_sram_ctrl_if: bundles the pipeline-side request/response signals and the
// 16-bit asynchronous SRAM pins of the MEM-stage SRAM controller.
//   slave  : the controller itself
//   master : the environment (EX/MEM + MEM/WB registers and the SRAM device)
interface mem_stage_sram_ctrl_if #(
    parameter int SRAM_AW = 18
);
    // Pipeline side
    logic               rd_en;
    logic               wr_en;
    logic [31:0]        address;
    logic [31:0]        write_data;
    logic [31:0]        read_data;
    logic               memReady;
    // SRAM side
    logic [SRAM_AW-1:0] sram_addr;
    logic [15:0]        sram_dq_out;
    logic [15:0]        sram_dq_in;
    logic               sram_dq_oe;
    logic               sram_we_n;
    logic               sram_oe_n;

    modport slave (
        input  rd_en, wr_en, address, write_data, sram_dq_in,
        output read_data, memReady, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
    );

    modport master (
        output rd_en, wr_en, address, write_data, sram_dq_in,
        input  read_data, memReady, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
    );
endinterface

// File: rtl/mem_stage_sram_ctrl.sv
// mem_stage_sram_ctrl: MEM-stage memory controller. A 32-bit load/store is split into
// two 16-bit SRAM accesses (low half-word first, then high half-word), each held for
// WAIT_CYCLES+1 cycles. memReady is low while an access is in flight so the pipeline
// freezes. SRAM pins are registered and computed from the next state so the strobes
// line up with the state they belong to.
// Optional feature macro: SRAM_ADDR_CHECK_EN -- out-of-range requests are rejected
// without touching the SRAM and flagged on a sticky addr_err output.
module mem_stage_sram_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          SRAM_AW     = 18,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
`ifdef SRAM_ADDR_CHECK_EN
    output logic addr_err,
`endif
    mem_stage_sram_ctrl_if.slave bus
);

    // 32-bit word index width: one SRAM address bit selects the half-word.
    localparam int         WORD_W    = SRAM_AW - 1;
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [3:0]          cnt_r;
    logic [3:0]          cnt_nxt_s;

    // Transaction latched on entry; later input changes are ignored.
    logic [WORD_W-1:0]   word_r;
    logic [31:0]         data_r;
    logic                wr_r;

    logic [31:0]         read_data_r;

    logic [SRAM_AW-1:0]  sram_addr_r;
    logic [SRAM_AW-1:0]  sram_addr_nxt_s;
    logic [15:0]         sram_dq_out_r;
    logic [15:0]         sram_dq_out_nxt_s;
    logic                sram_dq_oe_r;
    logic                sram_dq_oe_nxt_s;
    logic                sram_we_n_r;
    logic                sram_we_n_nxt_s;
    logic                sram_oe_n_r;
    logic                sram_oe_n_nxt_s;

    logic                req_s;
    logic                start_s;
    logic                phase_last_s;
    logic                in_range_s;
    logic                rd_clear_s;
    logic                mem_ready_s;
    logic [31:0]         offset_s;
    logic [WORD_W-1:0]   cap_word_s;
    logic [WORD_W-1:0]   eff_word_s;
    logic [31:0]         eff_data_s;
    logic                eff_wr_s;
    logic                unused_addr_bits_s;

    assign req_s        = bus.rd_en | bus.wr_en;
    assign start_s      = (state_r == ST_IDLE);
    assign phase_last_s = (cnt_r == WAIT_LAST);

    // Byte offset into the SRAM window; byte-in-word bits are dropped and the word
    // index is truncated, so out-of-window addresses alias when no check is built in.
    assign offset_s   = bus.address - BASE_ADDR;
    assign cap_word_s = offset_s[SRAM_AW:2];

    // Bits that do not take part in the word index (kept only for range checking).
    assign unused_addr_bits_s = ^{offset_s[31:SRAM_AW+1], offset_s[1:0]};

`ifdef SRAM_ADDR_CHECK_EN
    assign in_range_s = (bus.address >= BASE_ADDR) &&
                        (offset_s[31:SRAM_AW+1] == {(31-SRAM_AW){1'b0}});
    assign rd_clear_s = start_s & req_s & ~in_range_s & ~bus.wr_en;
`else
    assign in_range_s = 1'b1;
    assign rd_clear_s = 1'b0;
`endif

    // Transaction used to pre-compute the pins: fresh inputs when leaving IDLE,
    // otherwise the latched copy.
    assign eff_word_s = start_s ? cap_word_s     : word_r;
    assign eff_data_s = start_s ? bus.write_data : data_r;
    assign eff_wr_s   = start_s ? bus.wr_en      : wr_r;

    // Next-state and wait-counter logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = 4'd0;
                if (req_s) begin
                    if (in_range_s) begin
                        state_nxt_s = ST_LO;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LO: begin
                if (phase_last_s) begin
                    state_nxt_s = ST_HI;
                    cnt_nxt_s   = 4'd0;
                end else begin
                    cnt_nxt_s   = cnt_r + 4'd1;
                end
            end
            ST_HI: begin
                if (phase_last_s) begin
                    state_nxt_s = ST_DONE;
                    cnt_nxt_s   = 4'd0;
                end else begin
                    cnt_nxt_s   = cnt_r + 4'd1;
                end
            end
            ST_DONE: begin
                // Never restart from DONE: a request still held here is the one
                // just served and must not be replayed.
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 4'd0;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // Pipeline stall: busy in LO/HI, released in DONE or when idle with no request.
    always_comb begin
        mem_ready_s = 1'b0;
        case (state_r)
            ST_IDLE: mem_ready_s = ~req_s;
            ST_LO:   mem_ready_s = 1'b0;
            ST_HI:   mem_ready_s = 1'b0;
            ST_DONE: mem_ready_s = 1'b1;
            default: mem_ready_s = 1'b0;
        endcase
    end

    // SRAM pin values for the state being entered on the next edge.
    always_comb begin
        sram_addr_nxt_s   = {SRAM_AW{1'b0}};
        sram_dq_out_nxt_s = 16'h0000;
        sram_dq_oe_nxt_s  = 1'b0;
        sram_we_n_nxt_s   = 1'b1;
        sram_oe_n_nxt_s   = 1'b1;
        case (state_nxt_s)
            ST_LO: begin
                sram_addr_nxt_s = {eff_word_s, 1'b0};
                if (eff_wr_s) begin
                    sram_dq_oe_nxt_s  = 1'b1;
                    sram_we_n_nxt_s   = 1'b0;
                    sram_dq_out_nxt_s = eff_data_s[15:0];
                end else begin
                    sram_oe_n_nxt_s   = 1'b0;
                end
            end
            ST_HI: begin
                sram_addr_nxt_s = {eff_word_s, 1'b1};
                if (eff_wr_s) begin
                    sram_dq_oe_nxt_s  = 1'b1;
                    sram_we_n_nxt_s   = 1'b0;
                    sram_dq_out_nxt_s = eff_data_s[31:16];
                end else begin
                    sram_oe_n_nxt_s   = 1'b0;
                end
            end
            default: begin
                sram_addr_nxt_s = {SRAM_AW{1'b0}};
            end
        endcase
    end

    // State register and wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Latch address, store data and operation when a request is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_r <= {WORD_W{1'b0}};
            data_r <= 32'h0000_0000;
            wr_r   <= 1'b0;
        end else if (start_s && req_s) begin
            word_r <= cap_word_s;
            data_r <= bus.write_data;
            wr_r   <= bus.wr_en;
        end else begin
            word_r <= word_r;
            data_r <= data_r;
            wr_r   <= wr_r;
        end
    end

    // Load data: each half captured on the exit edge of its phase, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data_r <= 32'h0000_0000;
        end else if ((state_r == ST_LO) && phase_last_s && !wr_r) begin
            read_data_r[15:0] <= bus.sram_dq_in;
        end else if ((state_r == ST_HI) && phase_last_s && !wr_r) begin
            read_data_r[31:16] <= bus.sram_dq_in;
        end else if (rd_clear_s) begin
            read_data_r <= 32'h0000_0000;
        end else begin
            read_data_r <= read_data_r;
        end
    end

    // Registered SRAM pins; reset drops every strobe immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_addr_r   <= {SRAM_AW{1'b0}};
            sram_dq_out_r <= 16'h0000;
            sram_dq_oe_r  <= 1'b0;
            sram_we_n_r   <= 1'b1;
            sram_oe_n_r   <= 1'b1;
        end else begin
            sram_addr_r   <= sram_addr_nxt_s;
            sram_dq_out_r <= sram_dq_out_nxt_s;
            sram_dq_oe_r  <= sram_dq_oe_nxt_s;
            sram_we_n_r   <= sram_we_n_nxt_s;
            sram_oe_n_r   <= sram_oe_n_nxt_s;
        end
    end

`ifdef SRAM_ADDR_CHECK_EN
    logic addr_err_r;

    // Sticky flag for any request rejected as out of range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_err_r <= 1'b0;
        end else if (start_s && req_s && !in_range_s) begin
            addr_err_r <= 1'b1;
        end else begin
            addr_err_r <= addr_err_r;
        end
    end

    assign addr_err = addr_err_r;
`endif

    assign bus.read_data   = read_data_r;
    assign bus.memReady    = mem_ready_s;
    assign bus.sram_addr   = sram_addr_r;
    assign bus.sram_dq_out = sram_dq_out_r;
    assign bus.sram_dq_oe  = sram_dq_oe_r;
    assign bus.sram_we_n   = sram_we_n_r;
    assign bus.sram_oe_n   = sram_oe_n_r;

endmodule
